// File: rtl/apb16_reg_slave_pkg.sv
// -----------------------------------------------------------------------------
// apb16_reg_slave_pkg
// Shared definitions for the 16-bit APB register slave.
//   - Halfword register indices of the fixed control registers.
//   - Bit positions inside CTRL and IRQ_STAT.
//   - FSM state encoding for the APB handshake.
//   - Byte-strobe merge helper used by every writable register.
// -----------------------------------------------------------------------------
package apb16_reg_slave_pkg;

    // Halfword register indices
    localparam int IDX_CTRL       = 0;
    localparam int IDX_STATUS     = 1;
    localparam int IDX_IRQ_STAT   = 2;
    localparam int IDX_DATA_FIRST = 3;

    // CTRL bit positions
    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;

    // IRQ_STAT bit positions
    localparam int IRQ_DONE = 0;

    // Wait-state counter width (WAIT_CYCLES is limited to 0..15)
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // Merge write data into an existing halfword, one byte lane per strobe bit.
    function automatic logic [15:0] apply_strb(
        input logic [15:0] old_val,
        input logic [15:0] wdata,
        input logic [1:0]  strb
    );
        logic [15:0] res;
        res = old_val;
        if (strb[0]) res[7:0]  = wdata[7:0];
        if (strb[1]) res[15:8] = wdata[15:8];
        return res;
    endfunction

endpackage

// File: rtl/apb16_wait_ctr.sv
// -----------------------------------------------------------------------------
// apb16_wait_ctr
// Loadable down-counter that paces the APB wait states.
// Ports:
//   pclk      in  clock
//   preset_n  in  asynchronous active-low reset (counter -> 0)
//   load      in  load load_val (has priority over dec)
//   load_val  in  value to load
//   dec       in  decrement by one; saturates at zero
//   cnt_o     out current count
//   zero_o    out count == 0
// -----------------------------------------------------------------------------
module apb16_wait_ctr
    import apb16_reg_slave_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         pclk,
    input  logic         preset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/apb16_reg_slave.sv
// -----------------------------------------------------------------------------
// apb16_reg_slave
// 16-bit APB target register bank for the crypto accelerator control plane.
// Register map (halfword index = (paddr - BASE_ADDR) >> 1):
//   0 CTRL      bit0 start (self-clearing pulse, reads 0), bit1 irq_en, rest scratch
//   1 STATUS    read-only mirror of status_i (writes ignored, no error)
//   2 IRQ_STAT  bit0 done, write-1-to-clear
//   3..N-1      DATA, byte-granular RW
// Ports:
//   pclk, preset_n               clock, asynchronous active-low reset
//   psel, penable, pwrite        APB control
//   pstrb[1:0], paddr[31:0]      byte strobes, byte address (bit0 ignored)
//   pwdata[15:0]                 write data
//   prdata[15:0], pready, pslverr  response (prdata/pslverr zero unless pready)
//   status_i[15:0], busy_i       core status / busy inputs
//   start_o, irq_o               start pulse, interrupt
// -----------------------------------------------------------------------------
module apb16_reg_slave
    import apb16_reg_slave_pkg::*;
#(
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        pclk,
    input  logic        preset_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [1:0]  pstrb,
    input  logic [31:0] paddr,
    input  logic [15:0] pwdata,
    output logic [15:0] prdata,
    output logic        pready,
    output logic        pslverr,
    input  logic [15:0] status_i,
    input  logic        busy_i,
    output logic        start_o,
    output logic        irq_o
);

    localparam int          IDX_W = $clog2(NUM_REGS);
    localparam logic [31:0] SPAN  = 32'(2 * NUM_REGS);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] idx;

    assign offset   = paddr - BASE_ADDR;
    // The >= check catches addresses below the base, whose offset wraps.
    assign in_range = (paddr >= BASE_ADDR) && (offset < SPAN);
    assign idx      = offset[IDX_W:1];

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    apb_state_e       state_q;
    apb_state_e       state_d;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    apb16_wait_ctr #(.W(CNT_W)) u_wait_ctr (
        .pclk     (pclk),
        .preset_n (preset_n),
        .load     (cnt_load),
        .load_val (CNT_W'(WAIT_CYCLES)),
        .dec      (cnt_dec),
        .cnt_o    (cnt_val),
        .zero_o   (cnt_zero)
    );

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (psel && !penable) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (!psel)        state_d = ST_IDLE;   // abort
                else if (penable) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (!psel)                     state_d = ST_IDLE;   // abort
                else if (penable && cnt_zero)  state_d = ST_IDLE;   // completes now
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // pready is gated by psel so an abort landing on the final wait cycle
    // can never complete a transfer.
    always_comb begin
        cnt_load = (state_q == ST_IDLE) && psel && !penable;
        cnt_dec  = (state_q == ST_ACCESS) && psel && penable && !cnt_zero;
        pready   = (state_q == ST_ACCESS) && psel && penable && cnt_zero;
    end

    // ------------------------------------------------------------------
    // Register bank
    // ------------------------------------------------------------------
    logic        wr_commit;
    logic [15:0] ctrl_q, ctrl_d;
    logic [15:0] status_q, status_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        start_q, start_d;
    logic        irq_q, irq_d;
    logic        busy_fall;
    logic [15:0] rd_arr [NUM_REGS];

    assign wr_commit = pready && pwrite && in_range;
    assign busy_fall = busy_q && !busy_i;

    always_comb begin
        ctrl_d   = ctrl_q;
        start_d  = 1'b0;
        done_d   = done_q;
        busy_d   = busy_i;
        status_d = status_i;
        irq_d    = done_q && ctrl_q[CTRL_IRQ_EN];

        if (wr_commit && (idx == IDX_W'(IDX_CTRL))) begin
            ctrl_d  = apply_strb(ctrl_q, pwdata, pstrb);
            start_d = pstrb[0] && pwdata[CTRL_START];
        end
        // start is a pulse only; the stored bit is always 0 so it reads back 0.
        ctrl_d[CTRL_START] = 1'b0;

        if (wr_commit && (idx == IDX_W'(IDX_IRQ_STAT)) && pstrb[0] && pwdata[IRQ_DONE]) begin
            done_d = 1'b0;
        end
        // Completion event beats a coincident W1C so no event is lost.
        if (busy_fall) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            ctrl_q   <= '0;
            status_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
            irq_q    <= irq_d;
        end
    end

    assign rd_arr[IDX_CTRL]     = ctrl_q;
    assign rd_arr[IDX_STATUS]   = status_q;
    assign rd_arr[IDX_IRQ_STAT] = {15'd0, done_q};

    // General-purpose data registers
    genvar gi;
    generate
        for (gi = IDX_DATA_FIRST; gi < NUM_REGS; gi++) begin : gen_data
            logic [15:0] data_q;
            logic [15:0] data_d;

            always_comb begin
                data_d = data_q;
                if (wr_commit && (idx == IDX_W'(gi))) begin
                    data_d = apply_strb(data_q, pwdata, pstrb);
                end
            end

            always_ff @(posedge pclk or negedge preset_n) begin
                if (!preset_n) begin
                    data_q <= '0;
                end else begin
                    data_q <= data_d;
                end
            end

            assign rd_arr[gi] = data_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Response and outputs. prdata comes straight from register state so
    // it is stable for the whole pready cycle.
    // ------------------------------------------------------------------
    assign prdata  = (pready && in_range) ? rd_arr[idx] : 16'd0;
    assign pslverr = pready && !in_range;
    assign start_o = start_q;
    assign irq_o   = irq_q;

endmodule
